// File: rtl/usart_rx_fifo.sv
// usart_rx_fifo
// Receive-side buffer placed directly after usart_rx.
//   - Completes the rx_available / rx_acknowledge handshake (one capture per
//     rx_available assertion, however long it is held).
//   - Stores received bytes in a circular FIFO of DEPTH entries.
//   - Presents the head entry first-word-fall-through on data_out/data_valid.
//   - Sticky overflow / frame_error flags, cleared by clear_flags.
//
// Ports:
//   comm_clock     in   system clock, rising edge
//   reset          in   synchronous active-low reset
//   rx_data[7:0]   in   byte from usart_rx, valid with rx_available
//   rx_available   in   usart_rx holds a byte until acknowledged
//   rx_error       in   framing error for the current byte
//   rx_acknowledge out  registered acknowledge back to usart_rx
//   data_out[7:0]  out  head-of-FIFO byte (valid when data_valid)
//   data_valid     out  FIFO non-empty
//   data_read      in   pop strobe, ignored while empty
//   count          out  entries held, 0..DEPTH
//   overflow       out  sticky: byte dropped because FIFO was full
//   frame_error    out  sticky: byte arrived with rx_error=1
//   clear_flags    in   clears overflow and frame_error (wins over a set)
//   data_error     out  (USART_RX_FIFO_ERROR_TAG_EN only) error tag of head
//
// Optional feature macro: USART_RX_FIFO_ERROR_TAG_EN
//   defined   : 9-bit entries {rx_error, rx_data}; errored bytes are stored
//               and their tag is shown on data_error.
//   undefined : 8-bit entries; errored bytes are discarded.

module usart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 comm_clock,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_available,
    input  logic                 rx_error,
    output logic                 rx_acknowledge,
    output logic [7:0]           data_out,
    output logic                 data_valid,
    input  logic                 data_read,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic                 frame_error,
`ifdef USART_RX_FIFO_ERROR_TAG_EN
    output logic                 data_error,
`endif
    input  logic                 clear_flags
);

    localparam logic IDLE      = 1'b0;
    localparam logic WAIT_DROP = 1'b1;

`ifdef USART_RX_FIFO_ERROR_TAG_EN
    localparam int ENTRY_W = 9;
`else
    localparam int ENTRY_W = 8;
`endif

    localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);

    logic                 state;
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ENTRY_W-1:0]   mem [DEPTH];

    logic capture;
    logic pop;
    logic full;
    logic err_discard;
    logic wr_en;
    logic ovf_set;
    logic ferr_set;
    logic [ENTRY_W-1:0] wr_entry;

    // A capture happens only on the IDLE cycle that sees rx_available, so a
    // byte held for many cycles is written exactly once.
    assign capture = (state == IDLE) && rx_available;
    assign pop     = data_read && (count != '0);
    assign full    = (count == FULL_COUNT);

`ifdef USART_RX_FIFO_ERROR_TAG_EN
    assign err_discard = 1'b0;
    assign wr_entry    = {rx_error, rx_data};
`else
    assign err_discard = rx_error;
    assign wr_entry    = rx_data;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en    = capture && !err_discard && (!full || pop);
    assign ovf_set  = capture && !err_discard && full && !pop;
    assign ferr_set = capture && rx_error;

    // Handshake: ack follows the state; dropping rx_available returns to IDLE
    // and clears ack on the same edge.
    always_ff @(posedge comm_clock) begin
        if (!reset) begin
            state          <= IDLE;
            rx_acknowledge <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_available) begin
                        state          <= WAIT_DROP;
                        rx_acknowledge <= 1'b1;
                    end else begin
                        rx_acknowledge <= 1'b0;
                    end
                end
                default: begin
                    if (!rx_available) begin
                        state          <= IDLE;
                        rx_acknowledge <= 1'b0;
                    end else begin
                        rx_acknowledge <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage has no reset; contents are don't-care until written.
    always_ff @(posedge comm_clock) begin
        if (reset && wr_en) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge comm_clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ADDR_BITS'(1);
            if (pop)   rd_ptr <= rd_ptr + ADDR_BITS'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (ADDR_BITS+1)'(1);
                2'b01:   count <= count - (ADDR_BITS+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flags; a clear in the same cycle as an event wins.
    always_ff @(posedge comm_clock) begin
        if (!reset) begin
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else if (clear_flags) begin
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (ovf_set)  overflow    <= 1'b1;
            if (ferr_set) frame_error <= 1'b1;
        end
    end

    assign data_valid = (count != '0);
    assign data_out   = mem[rd_ptr][7:0];
`ifdef USART_RX_FIFO_ERROR_TAG_EN
    assign data_error = mem[rd_ptr][8];
`endif

endmodule
